seg_status_display: RTL



---
 rtl/seg_status_display.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/seg_status_display.sv
// seg_status_display: seven-segment status driver for the equaliser demo. It shows
// the band name (static or scrolling) and gain text. The gain field blinks for a
// hold period after any selection change.
// Ports: i_clk/i_rst_n (async active-low); i_sel_band[1:0], i_sel_gain[2:0] are raw
// switch inputs; o_hex[NUM_DIGITS-1:0] are active-low {g,f,e,d,c,b,a}, and the
// MSB index is the leftmost digit. o_hold is high while blinking. o_changed is a
// one-cycle change pulse.
// Option: define SEG_BLINK_EN to build the HOLD/blink state machine. Without it,
// the gain field is steady and o_hold is tied low.
module seg_status_display #(
  parameter int NUM_DIGITS = 8,
  parameter int TICK_DIV   = 50000,
  parameter int SCROLL_MS  = 300,
  parameter int BLINK_MS   = 250,
  parameter int HOLD_MS    = 2000
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [1:0]                 i_sel_band,
  input  logic [2:0]                 i_sel_gain,
  output logic [NUM_DIGITS-1:0][6:0] o_hex,
  output logic                       o_hold,
  output logic                       o_changed
);
  localparam int W  = NUM_DIGITS - 3;
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int SW = $clog2(SCROLL_MS + 1);
  localparam logic [PW-1:0] PRE_LAST    = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCROLL_LAST = SW'(SCROLL_MS - 1);

  localparam logic [6:0] BL = 7'b1111111, G0 = 7'b1000000, G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100, G6 = 7'b0000010, DASH = 7'b0111111;
  localparam logic [6:0] GB = 7'b0000000, GA = 7'b0001000, GS = 7'b0010010;
  localparam logic [6:0] GC = 7'b1000110, GE = 7'b0000110, GN = 7'b1001000;
  localparam logic [6:0] GH = 7'b0001001, GI = 7'b1001111, GG = 7'b1000010;

  // Character c (0..3) of the band name; any other position is blank.
  function automatic logic [6:0] band_glyph(input logic [1:0] b, input int c);
    band_glyph = BL;
    case (b)
      2'b00: case (c) 0: band_glyph = GB; 1: band_glyph = GA; 2, 3: band_glyph = GS; default: ; endcase
      2'b01: case (c) 0: band_glyph = GC; 1: band_glyph = GE; 2: band_glyph = GN; default: ; endcase
      2'b10: case (c) 0, 3: band_glyph = GH; 1: band_glyph = GI; 2: band_glyph = GG; default: ; endcase
      default: ;
    endcase
  endfunction

  function automatic logic [2:0][6:0] gain_glyphs(input logic [2:0] g);
    case (g)
      3'b000:  gain_glyphs = {BL, BL, G0};
      3'b001:  gain_glyphs = {BL, BL, G6};
      3'b010:  gain_glyphs = {BL, G1, G2};
      3'b011:  gain_glyphs = {DASH, G1, G2};
      3'b100:  gain_glyphs = {BL, DASH, G6};
      default: gain_glyphs = {BL, BL, BL};
    endcase
  endfunction

  // {band, gain} packed together through the synchroniser and change detector.
  logic [4:0]                 sync1, sync2, sel_q;
  logic [PW-1:0]              pre;
  logic [2:0]                 idx, idx_n;
  logic [SW-1:0]              scnt, scnt_n;
  logic                       tick, changed, band_changed, vis_n, hold_n;
  logic [NUM_DIGITS-1:0][6:0] hex_n;

  assign tick         = (pre == PRE_LAST);
  assign changed      = (sync2 != sel_q);
  assign band_changed = (sync2[4:3] != sel_q[4:3]);

  // Scroll position. A band change or an invalid band pins it to the start.
  always_comb begin
    idx_n  = idx;
    scnt_n = scnt;
    if (band_changed || sync2[4:3] == 2'b11) begin
      idx_n  = '0;
      scnt_n = '0;
    end else if (tick) begin
      if (scnt == SCROLL_LAST) begin
        scnt_n = '0;
        idx_n  = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
      end else begin
        scnt_n = scnt + SW'(1);
      end
    end
  end

`ifdef SEG_BLINK_EN
  localparam int HW = $clog2(HOLD_MS + 1);
  localparam int BW = $clog2(BLINK_MS + 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_MS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);

  typedef enum logic {IDLE, HOLD} state_t;
  state_t        state, state_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic          vis;

  always_comb begin
    state_n = state;
    hcnt_n  = hcnt;
    bcnt_n  = bcnt;
    vis_n   = vis;
    if (changed) begin
      // A change (first or repeated) always restarts the hold from a visible phase.
      state_n = HOLD;
      hcnt_n  = '0;
      bcnt_n  = '0;
      vis_n   = 1'b1;
    end else if (state == HOLD && tick) begin
      if (hcnt == HOLD_LAST) begin
        state_n = IDLE;
        hcnt_n  = '0;
        bcnt_n  = '0;
        vis_n   = 1'b1;
      end else begin
        hcnt_n = hcnt + HW'(1);
        if (bcnt == BLINK_LAST) begin
          bcnt_n = '0;
          vis_n  = ~vis;
        end else begin
          bcnt_n = bcnt + BW'(1);
        end
      end
    end
  end

  assign hold_n = (state_n == HOLD);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      hcnt  <= '0;
      bcnt  <= '0;
      vis   <= 1'b1;
    end else begin
      state <= state_n;
      hcnt  <= hcnt_n;
      bcnt  <= bcnt_n;
      vis   <= vis_n;
    end
  end
`else
  assign vis_n  = 1'b1;
  assign hold_n = 1'b0;
`endif

  // Render from next-state values so the new text, scroll start and visible phase
  // all appear on the same edge as o_changed.
  always_comb begin
    hex_n = '1;
    for (int p = 0; p < W; p++)
      hex_n[NUM_DIGITS-1-p] = band_glyph(sync2[4:3], (W >= 4) ? p : (int'(idx_n) + p) % 5);
    if (vis_n) hex_n[2:0] = gain_glyphs(sync2[2:0]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      sel_q     <= '0;
      pre       <= '0;
      idx       <= '0;
      scnt      <= '0;
      o_hex     <= '1;
      o_hold    <= 1'b0;
      o_changed <= 1'b0;
    end else begin
      sync1     <= {i_sel_band, i_sel_gain};
      sync2     <= sync1;
      sel_q     <= sync2;
      pre       <= tick ? '0 : pre + PW'(1);
      idx       <= idx_n;
      scnt      <= scnt_n;
      o_hex     <= hex_n;
      o_hold    <= hold_n;
      o_changed <= changed;
    end
  end
endmodule
